// File: rtl/nfc_pkg.sv
// Shared sizing for the NFC ECC register-file FIFO and synchronizer.
// Word/byte-lane widths and register-file depth/address width.
package nfc_pkg;

  localparam int DAT_WID  = 16;
  localparam int RF_DEPTH = 16;
  localparam int RF_AWID  = 4;
  localparam int LANE_WID = 8;
  localparam int LANES    = DAT_WID / LANE_WID;

endpackage

// File: rtl/nfc_pulse_stretch.sv
// Stretches fast-rate event pulses into one-slow-period pulses.
// Ports: clk, rst_n, slow_en (tick), pulse_in (event), pulse_out.
module nfc_pulse_stretch (
  input  logic clk,
  input  logic rst_n,
  input  logic slow_en,
  input  logic pulse_in,
  output logic pulse_out
);

  logic pend;

  // Events between ticks accumulate in pend; an event
  // coinciding with the tick goes straight to the output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend      <= 1'b0;
      pulse_out <= 1'b0;
    end else if (slow_en) begin
      pulse_out <= pend | pulse_in;
      pend      <= 1'b0;
    end else begin
      pend      <= pend | pulse_in;
    end
  end

endmodule

// File: rtl/nfc_asynch_ram_sync.sv
// Byte-lane register file with combinational read plus pulse stretcher.
// Ports: clk, rst_n, write[1:0], addr_wr, data_in, read, addr_rd,
//        data_out, slow_en, pulse_in, pulse_out.
module nfc_asynch_ram_sync #(
  parameter int DAT_WID  = nfc_pkg::DAT_WID,
  parameter int RF_DEPTH = nfc_pkg::RF_DEPTH,
  parameter int RF_AWID  = nfc_pkg::RF_AWID
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         write,
  input  logic [RF_AWID-1:0] addr_wr,
  input  logic [DAT_WID-1:0] data_in,
  input  logic               read,
  input  logic [RF_AWID-1:0] addr_rd,
  output logic [DAT_WID-1:0] data_out,
  input  logic               slow_en,
  input  logic               pulse_in,
  output logic               pulse_out
);

  import nfc_pkg::*;

  logic [DAT_WID-1:0] mem [RF_DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RF_DEPTH; i++)
        mem[i] <= '0;
    end else begin
      for (int l = 0; l < LANES; l++)
        if (write[l])
          mem[addr_wr][l*LANE_WID +: LANE_WID] <=
            data_in[l*LANE_WID +: LANE_WID];
    end
  end

  // No write bypass: a same-cycle write shows up after the edge.
  assign data_out = read ? mem[addr_rd] : '0;

  nfc_pulse_stretch u_stretch (
    .clk       (clk),
    .rst_n     (rst_n),
    .slow_en   (slow_en),
    .pulse_in  (pulse_in),
    .pulse_out (pulse_out)
  );

endmodule

// File: tb/tb_nfc_asynch_ram_sync.sv
// Directed bench for nfc_asynch_ram_sync.
// Memory lanes, read gating, same-cycle R/W and pulse stretching.
module tb_nfc_asynch_ram_sync;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  write;
  logic [3:0]  addr_wr;
  logic [15:0] data_in;
  logic        read;
  logic [3:0]  addr_rd;
  logic [15:0] data_out;
  logic        slow_en;
  logic        pulse_in;
  logic        pulse_out;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  nfc_asynch_ram_sync dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .write     (write),
    .addr_wr   (addr_wr),
    .data_in   (data_in),
    .read      (read),
    .addr_rd   (addr_rd),
    .data_out  (data_out),
    .slow_en   (slow_en),
    .pulse_in  (pulse_in),
    .pulse_out (pulse_out)
  );

  task automatic chk(input string tag,
                     input logic [15:0] obs,
                     input logic [15:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One clock with given slow_en/pulse_in, then check pulse_out.
  task automatic pstep(input string tag, input logic s,
                       input logic p, input logic exp);
    slow_en  = s;
    pulse_in = p;
    tick();
    chk(tag, {15'd0, pulse_out}, {15'd0, exp});
  endtask

  task automatic wr(input logic [1:0] w, input logic [3:0] a,
                    input logic [15:0] d);
    write   = w;
    addr_wr = a;
    data_in = d;
    tick();
    write   = 2'b00;
  endtask

  task automatic rd(input string tag, input logic [3:0] a,
                    input logic [15:0] exp);
    read    = 1'b1;
    addr_rd = a;
    #1;
    chk(tag, data_out, exp);
  endtask

  initial begin
    rst_n    = 1'b0;
    write    = 2'b00;
    addr_wr  = '0;
    data_in  = '0;
    read     = 1'b0;
    addr_rd  = '0;
    slow_en  = 1'b0;
    pulse_in = 1'b0;
    #12 rst_n = 1'b1;
    tick();

    chk("rst_pulse", {15'd0, pulse_out}, 16'h0000);
    for (int i = 0; i < 16; i++)
      rd($sformatf("rst_mem%0d", i), 4'(i), 16'h0000);

    wr(2'b11, 4'd3, 16'hA55A);
    rd("full_wr", 4'd3, 16'hA55A);
    read = 1'b0;
    #1;
    chk("read_gate", data_out, 16'h0000);

    wr(2'b01, 4'd5, 16'h1234);
    rd("lane_lo", 4'd5, 16'h0034);
    wr(2'b10, 4'd5, 16'hAB00);
    rd("lane_hi", 4'd5, 16'hAB34);
    rd("lane_other", 4'd3, 16'hA55A);

    wr(2'b11, 4'd7, 16'h1111);
    write   = 2'b11;
    addr_wr = 4'd7;
    data_in = 16'h2222;
    rd("rw_before", 4'd7, 16'h1111);
    tick();
    write = 2'b00;
    chk("rw_after", data_out, 16'h2222);
    wr(2'b11, 4'd15, 16'hBEEF);
    rd("addr15", 4'd15, 16'hBEEF);
    rd("addr0", 4'd0, 16'h0000);

    // single event between ticks
    pstep("p1_a", 1'b1, 1'b0, 1'b0);
    pstep("p1_b", 1'b0, 1'b1, 1'b0);
    pstep("p1_c", 1'b1, 1'b0, 1'b1);
    pstep("p1_d", 1'b0, 1'b0, 1'b1);
    pstep("p1_e", 1'b1, 1'b0, 1'b0);
    pstep("p1_f", 1'b0, 1'b0, 1'b0);

    // two events in one window, second coinciding with the tick
    pstep("p2_a", 1'b0, 1'b1, 1'b0);
    pstep("p2_b", 1'b1, 1'b1, 1'b1);
    pstep("p2_c", 1'b0, 1'b0, 1'b1);
    pstep("p2_d", 1'b1, 1'b0, 1'b0);
    pstep("p2_e", 1'b0, 1'b0, 1'b0);

    // held pulse_in keeps pulse_out high
    pstep("p3_a", 1'b1, 1'b1, 1'b1);
    pstep("p3_b", 1'b0, 1'b1, 1'b1);
    pstep("p3_c", 1'b1, 1'b1, 1'b1);
    pstep("p3_d", 1'b0, 1'b0, 1'b1);
    pstep("p3_e", 1'b1, 1'b0, 1'b0);

    // slow_en stuck high: pure 1-clk delay
    pstep("p4_a", 1'b1, 1'b1, 1'b1);
    pstep("p4_b", 1'b1, 1'b0, 1'b0);
    pstep("p4_c", 1'b1, 1'b1, 1'b1);
    pstep("p4_d", 1'b1, 1'b0, 1'b0);

    // pending event dropped by reset
    pstep("p5_a", 1'b0, 1'b1, 1'b0);
    pulse_in = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    rd("rst_mid_mem", 4'd3, 16'h0000);
    #1 rst_n = 1'b1;
    pstep("p5_b", 1'b1, 1'b0, 1'b0);
    pstep("p5_c", 1'b0, 1'b0, 1'b0);
    pstep("p5_d", 1'b1, 1'b0, 1'b0);
    rd("rst_mid_mem5", 4'd5, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/nfc_asynch_ram_sync.md
# nfc_asynch_ram_sync

Single-clock register-file FIFO and pulse-stretching synchronizer for the NFC ECC path. It holds up to 16 words of 16 bits: ECC encode bytes, or decode error addresses. Writes use two independent byte lanes. Reads are combinational on a random address. A companion synchronizer turns single-cycle fast-rate event pulses into pulses that a slow-rate consumer samples exactly once. The slow rate is marked by a phase strobe.

## Interface
Parameters:
- DAT_WID, 16, word width; must be 16 because there are two 8-bit byte lanes.
- RF_DEPTH, 16, number of words.
- RF_AWID, 4, address width; equals log2(RF_DEPTH).

Ports:
- clk  in  1  the single clock, on the rising edge. One clock; reset is asynchronous and active-low.
- rst_n  in  1  asynchronous, active-low reset.
- write  in  2  byte-lane write enables: write[0] writes bits 7:0, write[1] writes bits 15:8.
- addr_wr  in  RF_AWID  write address.
- data_in  in  DAT_WID  write data; each lane takes its own byte.
- read  in  1  read strobe; gates data_out.
- addr_rd  in  RF_AWID  read address.
- data_out  out  DAT_WID  read data.
- slow_en  in  1  slow-domain tick strobe, one cycle wide (typically every 2nd clk).
- pulse_in  in  1  event pulse, one or more cycles.
- pulse_out  out  1  stretched event, aligned to slow_en.

## Operation
- Memory: RF_DEPTH × DAT_WID flops, cleared to 0 by reset.
- Write, at clk edge:
  - if write[0]: mem[addr_wr][7:0] <= data_in[7:0].
  - if write[1]: mem[addr_wr][15:8] <= data_in[15:8].
  - Lanes are independent; both set writes the full word.
- Read is combinational:
  - data_out = read ? mem[addr_rd] : 0.
  - No read latency; addr_rd changes are reflected in the same cycle.
- Read and write to the same address in one cycle: data_out shows the old contents before the edge and the new contents after it. There is no bypass.
- No full/empty tracking. Address counters and wrap-around (15 → 0) are the caller's job. This block never blocks a write.
- Synchronizer state: pend (1 bit), pulse_out (registered).
  - Edge with slow_en=1: pulse_out <= pend | pulse_in; pend <= 0.
  - Edge with slow_en=0: pulse_out holds; pend <= pend | pulse_in.
  - Result: pulse_out is high for exactly one slow period (from one slow_en edge to the next). A consumer sampling at slow_en sees it once.
  - Events that arrive within the same slow window merge into one output pulse.
  - An event that coincides with the slow_en edge is reported at that edge, not lost.
  - If pulse_in stays asserted, pulse_out stays high continuously.

## Timing
- Reset values (asynchronous): mem = 0, pend = 0, pulse_out = 0, data_out = 0.
- Write-to-read latency: 1 clk. Data written at edge N is visible on data_out after edge N.
- pulse_in → pulse_out latency: 1 clk if slow_en coincides, otherwise up to one slow period + 1 clk.
- Reset asserted mid-operation clears pending events and memory immediately. The first edge after rst_n rises behaves as from the reset state.
- slow_en held constantly at 1 degenerates to pulse_out = pulse_in delayed by 1 clk.

## Structure
- Shared package nfc_pkg: DAT_WID, RF_DEPTH, RF_AWID, and byte lane width 8.
- Sub-module nfc_pulse_stretch: pend/pulse_out logic, one instance.
- Top: the memory array, lane write decode and read gating.

## Test plan
- Reset, then read=1 at addr_rd=0..15 → data_out=0x0000 for every address. pulse_out=0.
- write=2'b11, addr_wr=3, data_in=0xA55A; then read addr_rd=3 → 0xA55A. With read=0 → 0x0000.
- Byte lanes:
  - write=2'b01, addr 5, data 0x1234 → read 0x0034.
  - Then write=2'b10, addr 5, data 0xAB00 → read 0xAB34.
- Same-cycle read/write on addr 7:
  - old value 0x1111, new 0x2222.
  - data_out=0x1111 before the edge, 0x2222 after it.
- slow_en toggling every other cycle; single pulse_in in a cycle with slow_en=0 → pulse_out=1 from the next slow_en edge for exactly 2 clks.
- Two pulse_in events in one slow window → one 2-clk pulse_out.
- pulse_in asserted, then rst_n pulsed low before the slow_en edge → pulse_out stays 0.
